// File: rtl/spdif_transmitter.sv
// IEC 60958 consumer S/PDIF biphase-mark transmitter for 16-bit stereo PCM.
// Define SPDIF_TX_CHANNEL_STATUS_EN to send CHANNEL_STATUS in frames 0..31.
module spdif_transmitter #(
    parameter logic [31:0] CHANNEL_STATUS = 32'h0200_0004,
    parameter int unsigned BLOCK_FRAMES   = 192
) (
    input  logic        Clk,
    input  logic        nReset,
    input  logic        Cell_Ena,
    input  logic [15:0] Audio_Left,
    input  logic [15:0] Audio_Right,
    input  logic        Sample_Valid,
    output logic        Sample_Ready,
    output logic        S_PDIF_Out,
    output logic        Frame_Start,
    output logic        Underrun
);
    localparam int unsigned FW    = (BLOCK_FRAMES > 1) ? $clog2(BLOCK_FRAMES) : 1;
    localparam logic [7:0]  PRE_B = 8'b1110_1000;
    localparam logic [7:0]  PRE_M = 8'b1110_0010;
    localparam logic [7:0]  PRE_W = 8'b1110_0100;

    logic [6:0]    cell_q, cell_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          hold_full_q, hold_full_d;
    logic [15:0]   hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic          ever_loaded_q, ever_loaded_d;
    logic [15:0]   frm_l_q, frm_l_d, frm_r_q, frm_r_d;
    logic          frm_v_q, frm_v_d;
    logic          line_q, line_d;
    logic          pre_inv_q, pre_inv_d;
    logic          parity_q, parity_d;
    logic          frame_start_q, frame_start_d;
    logic          underrun_q, underrun_d;

    logic [4:0]    slot;
    logic [3:0]    sbit_idx;
    logic [15:0]   sample;
    logic [7:0]    pre_pat;
    logic          data_bit, pre_inv, c_bit;

`ifdef SPDIF_TX_CHANNEL_STATUS_EN
    assign c_bit = (32'(frame_q) < 32) ? CHANNEL_STATUS[5'(frame_q)] : 1'b0;
`else
    // Status word not carried in this build.
    logic cs_unused;
    assign cs_unused = ^CHANNEL_STATUS;
    assign c_bit     = 1'b0;
`endif

    assign slot     = cell_q[5:1];
    assign sbit_idx = 4'(slot - 5'd12);
    assign sample   = cell_q[6] ? frm_r_q : frm_l_q;
    assign pre_pat  = cell_q[6] ? PRE_W : ((frame_q == '0) ? PRE_B : PRE_M);
    assign pre_inv  = (cell_q[5:0] == '0) ? line_q : pre_inv_q;

    always_comb begin
        data_bit = 1'b0;
        if (slot >= 5'd12 && slot <= 5'd27) data_bit = sample[sbit_idx];
        else if (slot == 5'd28)             data_bit = frm_v_q;
        else if (slot == 5'd30)             data_bit = c_bit;
        else if (slot == 5'd31)             data_bit = parity_q;
    end

    always_comb begin
        cell_d        = cell_q;
        frame_d       = frame_q;
        hold_full_d   = hold_full_q;
        hold_l_d      = hold_l_q;
        hold_r_d      = hold_r_q;
        ever_loaded_d = ever_loaded_q;
        frm_l_d       = frm_l_q;
        frm_r_d       = frm_r_q;
        frm_v_d       = frm_v_q;
        line_d        = line_q;
        pre_inv_d     = pre_inv_q;
        parity_d      = parity_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;

        if (Sample_Valid && !hold_full_q) begin
            hold_full_d = 1'b1;
            hold_l_d    = Audio_Left;
            hold_r_d    = Audio_Right;
        end

        if (Cell_Ena) begin
            cell_d = cell_q + 7'd1;
            // Accept and load cannot both hit the holding register: accept implies it is empty.
            if (cell_q == '0) begin
                frame_start_d = 1'b1;
                if (hold_full_q) begin
                    frm_l_d       = hold_l_q;
                    frm_r_d       = hold_r_q;
                    frm_v_d       = 1'b0;
                    hold_full_d   = 1'b0;
                    ever_loaded_d = 1'b1;
                end else begin
                    frm_l_d    = '0;
                    frm_r_d    = '0;
                    frm_v_d    = 1'b1;
                    underrun_d = ever_loaded_q;
                end
            end
            if (cell_q == '1)
                frame_d = (frame_q == FW'(BLOCK_FRAMES - 1)) ? '0 : frame_q + 1'b1;

            if (slot < 5'd4) begin
                pre_inv_d = pre_inv;
                line_d    = pre_pat[3'd7 - cell_q[2:0]] ^ pre_inv;
                parity_d  = 1'b0;
            end else if (!cell_q[0]) begin
                line_d = ~line_q;
            end else begin
                line_d = line_q ^ data_bit;
                if (slot != 5'd31) parity_d = parity_q ^ data_bit;
            end
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            cell_q        <= '0;
            frame_q       <= '0;
            hold_full_q   <= 1'b0;
            hold_l_q      <= '0;
            hold_r_q      <= '0;
            ever_loaded_q <= 1'b0;
            frm_l_q       <= '0;
            frm_r_q       <= '0;
            frm_v_q       <= 1'b1;
            line_q        <= 1'b0;
            pre_inv_q     <= 1'b0;
            parity_q      <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            cell_q        <= cell_d;
            frame_q       <= frame_d;
            hold_full_q   <= hold_full_d;
            hold_l_q      <= hold_l_d;
            hold_r_q      <= hold_r_d;
            ever_loaded_q <= ever_loaded_d;
            frm_l_q       <= frm_l_d;
            frm_r_q       <= frm_r_d;
            frm_v_q       <= frm_v_d;
            line_q        <= line_d;
            pre_inv_q     <= pre_inv_d;
            parity_q      <= parity_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign Sample_Ready = ~hold_full_q;
    assign S_PDIF_Out   = line_q;
    assign Frame_Start  = frame_start_q;
    assign Underrun     = underrun_q;
endmodule

// File: doc/spdif_transmitter.md
Name: spdif_transmitter

Overview:
- Serialises 16-bit stereo PCM pairs into an IEC 60958 consumer S/PDIF biphase-mark stream for the S_PDIF_Out and nS_PDIF pins.
- The audio producer, e.g. the USB audio path at 48 kHz, hands over sample pairs through a valid/ready handshake.
- The block builds left/right subframes with preambles, V/U/C/P bits and a 192-frame block structure.
- Line timing comes from an external half-cell strobe at 128×fs: 6.144 MHz for 48 kHz.

Parameters:
- CHANNEL_STATUS, 32'h0200_0004, channel-status bits 0..31. Bit i is sent in frame i. Default means consumer, copy permitted, fs = 48 kHz.
- BLOCK_FRAMES, 192, frames per channel-status block.

Ports:
- Clk  input  1  system clock, 50 MHz.
- nReset  input  1  asynchronous, active-low reset.
- Cell_Ena  input  1  one-Clk pulse per biphase half-cell (128 per frame).
- Audio_Left  input  16  left sample, two's complement.
- Audio_Right  input  16  right sample, two's complement.
- Sample_Valid  input  1  producer presents a sample pair.
- Sample_Ready  output  1  holding register empty; pair accepted when Valid && Ready at posedge Clk.
- S_PDIF_Out  output  1  biphase-mark line output.
- Frame_Start  output  1  one-Clk pulse when the first half-cell of a left subframe is driven.
- Underrun  output  1  one-Clk pulse when a frame starts with no pair available.

Behaviour:
- Reset (async assert, sync release):
  - S_PDIF_Out=0, Sample_Ready=1, Frame_Start=0, Underrun=0.
  - Cell counter=0, frame counter=0, holding register empty, "ever_loaded" flag=0.
- Cell counter, 7 bits, advances only on Cell_Ena and wraps 127→0:
  - cell[6] selects the subframe (0=left, 1=right).
  - cell[5:1] selects the time slot 0..31.
  - cell[0] selects the half (0=first).
- Each output update is registered on the Clk edge at which Cell_Ena is sampled high: 1-Clk latency.
- Frame load at Cell_Ena with cell=0:
  - If the holding register is full, the pair moves into the frame register, the holding register is marked empty and Sample_Ready goes to 1.
  - If it is empty, the frame register is loaded with zeros and V=1 for both subframes. Underrun pulses only if ever_loaded=1.
  - Frame_Start pulses in the same cycle.
- Handshake:
  - Accept clears Sample_Ready the next cycle.
  - An accept and a frame load in the same cycle: the load takes the old holding contents if full; otherwise the new pair goes to the holding register and the frame underruns.
- Subframe slots:
  - Slots 0-3: preamble, 8 half-cells sent MSB first. B=11101000 (left, frame 0), M=11100010 (other left), W=11100100 (right).
  - Preamble cell level is pattern bit if the line level before the preamble is 0, else the inverted bit.
  - Slots 4-11: 0, the aux/LSB pad.
  - Slots 12-27: sample, LSB first.
  - Slot 28: V (0 normally, 1 on underrun).
  - Slot 29: U=0.
  - Slot 30: C.
  - Slot 31: P, even parity over slots 4-30.
- Biphase mark, slots 4-31:
  - Line toggles at the first half of every slot.
  - Line toggles again at the second half if the bit is 1.
- Frame counter:
  - Increments at the end of each right subframe and wraps BLOCK_FRAMES-1→0.
  - Frame 0 uses preamble B.
  - The C bit is identical in both subframes of a frame.
- Reset mid-frame aborts the stream. After release the first frame starts at cell 0 with B.

Optional Feature:
- Macro SPDIF_TX_CHANNEL_STATUS_EN.
- Defined: C = CHANNEL_STATUS[frame] for frames 0..31, C = 0 for frames 32..191.
- Undefined: C=0 in every frame. CHANNEL_STATUS is ignored and no status logic is synthesised. Parity still covers C.

Test Plan:
- Reset with Cell_Ena toggling and no samples → S_PDIF_Out biphase of zeros with V=1; preamble order B,W,M,W…; Underrun never pulses; Sample_Ready=1.
- Left=16'h0001, Right=16'h8000 accepted before cell 0 → decoded slot 12 left=1, slot 27 right=1; parity bits make each subframe's slots 4-31 even; V=0.
- Run 193 frames with the macro defined → decoded C bits of frames 2 and 25 are 1, all others 0; B appears at frames 0 and 192 only.
- Same run with the macro undefined → all C=0; parity still even.
- Supply one pair then stop → the next frame is silent with V=1 and Underrun pulses exactly once, in the Frame_Start cycle.
- Assert Sample_Valid in the same Clk as the cell-0 load with the holding register empty → frame underruns; the pair is sent in the following frame; Sample_Ready low for exactly that interval.
